ram_responder: RTL and testbench

- RAM-side responder for the cache/memory-control RAM interface.
- Accepts the arbitrated single-port request (ramREN/ramWEN/ramaddr/ramstore) and returns ramload plus ramstate (FREE/BUSY/ACCESS/ERROR) after a configurable wait latency.
- Holds a word-addressed backing store.
- Used as the RAM endpoint in simulation and synthesis tops, behind the arbiter.

---
 rtl/ram_responder_if.sv | 20 ++
 rtl/ram_responder.sv | 112 +++++++++++
 tb/tb_ram_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// RAM-side request/response bundle between the arbiter and the RAM responder.
// The master drives requests; the slave returns load data and ramstate.
interface ram_responder_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM endpoint with a fixed BUSY wait before ACCESS.
// Requests are level-held; any change during the wait restarts it.
module ram_responder #(
    parameter int WORDS = 1024,
    parameter int LAT   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    ram_responder_if.slave  bus
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACC  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            op_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [31:0]     load_q;
    logic [31:0]     mem [WORDS];

    logic            req;
    logic            bad;
    logic            chg;
    logic            fire;
    logic            mem_we;
    logic [AW-1:0]   idx;

    assign req = bus.ramREN | bus.ramWEN;
    assign bad = (bus.ramREN & bus.ramWEN)
               | (bus.ramaddr[1:0] != 2'b00)
               | ({2'b00, bus.ramaddr[31:2]} >= 32'(WORDS));
    assign idx = bus.ramaddr[AW+1:2];

    // The arbiter may swap requesters mid-wait; treat that as a new request.
    assign chg = (bus.ramWEN != op_q)
               | (bus.ramaddr != addr_q)
               | (bus.ramWEN & (bus.ramstore != data_q));

    assign fire = (state_q == BUSY) & req & ~bad & ~chg
                & (cnt_q == '0);
    assign mem_we = fire & bus.ramWEN & ~RST;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= bus.ramstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            load_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && bad) begin
                        state_q <= ERR;
                    end else if (req) begin
                        op_q    <= bus.ramWEN;
                        addr_q  <= bus.ramaddr;
                        data_q  <= bus.ramstore;
                        cnt_q   <= CW'(LAT - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else if (bad) begin
                        state_q <= ERR;
                    end else if (chg) begin
                        op_q   <= bus.ramWEN;
                        addr_q <= bus.ramaddr;
                        data_q <= bus.ramstore;
                        cnt_q  <= CW'(LAT - 1);
                    end else if (cnt_q == '0) begin
                        state_q <= ACC;
                        load_q  <= bus.ramWEN ? bus.ramstore : mem[idx];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACC: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramload  = load_q;
    assign bus.ramstate = state_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed, table-driven bench for ram_responder (WORDS=1024, LAT=2).
// Each row is one cycle of inputs and the outputs expected after that edge.
module tb_ram_responder;
    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BSY  = 2'd1;
    localparam logic [1:0] ACS  = 2'd2;
    localparam logic [1:0] ERRS = 2'd3;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] ld;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    ram_responder_if bus();

    ram_responder #(.WORDS(1024), .LAT(2)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic v(input logic ren, input logic wen,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] st, input logic [31:0] ld);
        vec_t r;
        r.ren = ren; r.wen = wen; r.addr = addr; r.data = data;
        r.st = st; r.ld = ld;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.ramREN = ren; bus.ramWEN = wen;
        bus.ramaddr = addr; bus.ramstore = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_word(input logic [31:0] addr,
                             input logic [31:0] exp, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        drive(1'b1, 1'b0, addr, 32'h0);
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            n++;
            if (bus.ramstate == ACS) seen = 1;
        end
        chk({name, "_seen"}, {31'b0, seen}, 32'd1);
        chk({name, "_lat"}, n, 32'd3);
        chk({name, "_load"}, bus.ramload, exp);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk({name, "_free"}, {30'b0, bus.ramstate}, {30'b0, FREE});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) v(0, 0, 32'h0, 32'h0, FREE, 32'h0);
        v(0, 1, 32'h0, 32'h0000C0DE, BSY, 32'h0);
        v(0, 1, 32'h0, 32'h0000C0DE, BSY, 32'h0);
        v(0, 1, 32'h0, 32'h0000C0DE, ACS, 32'h0000C0DE);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h0000C0DE);
        v(0, 1, 32'h40, 32'hDEADBEEF, BSY, 32'h0000C0DE);
        v(0, 1, 32'h40, 32'hDEADBEEF, BSY, 32'h0000C0DE);
        v(0, 1, 32'h40, 32'hDEADBEEF, ACS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, ACS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(0, 1, 32'h80, 32'h0BADF00D, BSY, 32'hDEADBEEF);
        v(0, 1, 32'h80, 32'h0BADF00D, BSY, 32'hDEADBEEF);
        v(0, 1, 32'h80, 32'h0BADF00D, ACS, 32'h0BADF00D);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h0BADF00D);
        v(0, 1, 32'h100, 32'h11110100, BSY, 32'h0BADF00D);
        v(0, 1, 32'h100, 32'h11110100, BSY, 32'h0BADF00D);
        v(0, 1, 32'h100, 32'h11110100, ACS, 32'h11110100);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h11110100);
        v(0, 1, 32'h200, 32'hA5A50200, BSY, 32'h11110100);
        v(0, 1, 32'h200, 32'hA5A50200, BSY, 32'h11110100);
        v(0, 1, 32'h200, 32'hA5A50200, ACS, 32'hA5A50200);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hA5A50200);
        // mid-wait address switch restarts the full wait
        v(1, 0, 32'h100, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h100, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h200, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h200, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h200, 32'h0, ACS, 32'hA5A50200);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hA5A50200);
        v(1, 0, 32'h100, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h100, 32'h0, BSY, 32'hA5A50200);
        v(1, 0, 32'h100, 32'h0, ACS, 32'h11110100);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h11110100);
        v(1, 1, 32'h40, 32'hBAD0BAD0, ERRS, 32'h11110100);
        v(1, 1, 32'h40, 32'hBAD0BAD0, ERRS, 32'h11110100);
        v(1, 0, 32'h40, 32'h0, ERRS, 32'h11110100);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h11110100);
        v(1, 0, 32'h40, 32'h0, BSY, 32'h11110100);
        v(1, 0, 32'h40, 32'h0, BSY, 32'h11110100);
        v(1, 0, 32'h40, 32'h0, ACS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(0, 1, 32'h42, 32'hBAD0BAD0, ERRS, 32'hDEADBEEF);
        v(0, 1, 32'h42, 32'hBAD0BAD0, ERRS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, ACS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(0, 1, 32'h1000, 32'hBAD0BAD0, ERRS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);
        v(1, 0, 32'h0, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h0, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h0, 32'h0, ACS, 32'h0000C0DE);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h0000C0DE);
        // withdrawn during BUSY: no ACCESS, load held
        v(1, 0, 32'h40, 32'h0, BSY, 32'h0000C0DE);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h0000C0DE);
        v(0, 0, 32'h0, 32'h0, FREE, 32'h0000C0DE);
        // request held through ACCESS is re-serviced after one FREE
        v(1, 0, 32'h40, 32'h0, BSY, 32'h0000C0DE);
        v(1, 0, 32'h40, 32'h0, BSY, 32'h0000C0DE);
        v(1, 0, 32'h40, 32'h0, ACS, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, FREE, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, BSY, 32'hDEADBEEF);
        v(1, 0, 32'h40, 32'h0, ACS, 32'hDEADBEEF);
        v(0, 0, 32'h0, 32'h0, FREE, 32'hDEADBEEF);

        step();
        step();
        chk("rst_state", {30'b0, bus.ramstate}, {30'b0, FREE});
        chk("rst_load", bus.ramload, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data);
            step();
            chk($sformatf("v%0d_state", i), {30'b0, bus.ramstate},
                {30'b0, vecs[i].st});
            chk($sformatf("v%0d_load", i), bus.ramload, vecs[i].ld);
        end

        drive(1'b0, 1'b1, 32'h80, 32'h12345678);
        step();
        chk("rw_busy", {30'b0, bus.ramstate}, {30'b0, BSY});
        rst = 1'b1;
        step();
        chk("rw_rst_state", {30'b0, bus.ramstate}, {30'b0, FREE});
        chk("rw_rst_load", bus.ramload, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("rw_idle", {30'b0, bus.ramstate}, {30'b0, FREE});
        read_word(32'h80, 32'h0BADF00D, "rw_readback");
        read_word(32'h200, 32'hA5A50200, "rd200");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
